// File: rtl/multicycle_control_if.sv
// Memory handshake bundle between multicycle_control (master) and the shared
// instruction/data memory port (slave).
interface multicycle_control_if;
    logic mem_req;
    logic mem_we;
    logic addr_sel;
    logic mem_ready;

    modport master (output mem_req, mem_we, addr_sel, input mem_ready);
    modport slave  (input mem_req, mem_we, addr_sel, output mem_ready);
endinterface

// File: rtl/multicycle_control.sv
// Multi-cycle RV32I sequencer: per-state control strobes, variable-latency memory handshake.
// Optional performance counters are built when MULTICYCLE_CONTROL_PERF_EN is defined.
//
// state    | meaning
// FETCH    | read instruction at PC, load IR and PC+4 on mem_ready
// DECODE   | classify instr, detect illegal encodings
// EXEC_R   | ALU on rs1, rs2
// EXEC_I   | ALU on rs1, immediate
// MEM_ADDR | effective address rs1 + imm
// MEM_RD   | load access at ALU result
// MEM_WR   | store access at ALU result
// WB_ALU   | write ALU result to rd
// WB_MEM   | write load data to rd
// BRANCH   | compare rs1/rs2, take target when equal
// TRAP     | illegal instruction, parked until reset
module multicycle_control (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [31:0]                 instr,
    input  logic                        alu_zero,
    multicycle_control_if.master        mem,
    output logic                        ir_write,
    output logic                        pc_write,
    output logic                        pc_src,
    output logic                        reg_write,
    output logic                        result_src,
    output logic                        alu_src_b,
    output logic [2:0]                  alu_op,
    output logic                        trap,
    output logic [3:0]                  state,
    output logic [31:0]                 cycle_count,
    output logic [31:0]                 instret_count
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_EXEC_R   = 4'd2,
        S_EXEC_I   = 4'd3,
        S_MEM_ADDR = 4'd4,
        S_MEM_RD   = 4'd5,
        S_MEM_WR   = 4'd6,
        S_WB_ALU   = 4'd7,
        S_WB_MEM   = 4'd8,
        S_BRANCH   = 4'd9,
        S_TRAP     = 4'd10
    } state_t;

    localparam logic [2:0] ALU_ADD = 3'd0;
    localparam logic [2:0] ALU_SUB = 3'd1;
    localparam logic [2:0] ALU_AND = 3'd2;
    localparam logic [2:0] ALU_OR  = 3'd3;
    localparam logic [2:0] ALU_XOR = 3'd4;
    localparam logic [2:0] ALU_SLL = 3'd5;
    localparam logic [2:0] ALU_SRL = 3'd6;
    localparam logic [2:0] ALU_SLT = 3'd7;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    state_t     cur;
    state_t     decode_next;
    logic [2:0] exec_op;
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic       rd_nonzero;
    logic       req;
    logic       we;
    logic       asel;
    logic       unused_instr_bits;

    assign opcode            = instr[6:0];
    assign funct3            = instr[14:12];
    assign funct7            = instr[31:25];
    assign rd_nonzero        = |instr[11:7];
    assign unused_instr_bits = ^instr[24:15];

    always_comb begin
        decode_next = S_TRAP;
        case (opcode)
            OP_R: begin
                if (funct3 != 3'b011 &&
                    (funct7 == 7'b0000000 || (funct7 == 7'b0100000 && funct3 == 3'b000)))
                    decode_next = S_EXEC_R;
            end
            OP_I: begin
                if (funct3 != 3'b011 && !(funct3 == 3'b101 && funct7 == 7'b0100000))
                    decode_next = S_EXEC_I;
            end
            OP_LOAD, OP_STORE: begin
                if (funct3 == 3'b010)
                    decode_next = S_MEM_ADDR;
            end
            OP_BRANCH: begin
                if (funct3 == 3'b000)
                    decode_next = S_BRANCH;
            end
            default: decode_next = S_TRAP;
        endcase
    end

    always_comb begin
        exec_op = ALU_ADD;
        case (funct3)
            3'b000: exec_op = (opcode == OP_R && funct7[5]) ? ALU_SUB : ALU_ADD;
            3'b001: exec_op = ALU_SLL;
            3'b010: exec_op = ALU_SLT;
            3'b100: exec_op = ALU_XOR;
            3'b101: exec_op = ALU_SRL;
            3'b110: exec_op = ALU_OR;
            3'b111: exec_op = ALU_AND;
            default: exec_op = ALU_ADD;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cur <= S_FETCH;
        end else begin
            case (cur)
                S_FETCH:    if (mem.mem_ready) cur <= S_DECODE;
                S_DECODE:   cur <= decode_next;
                S_EXEC_R:   cur <= S_WB_ALU;
                S_EXEC_I:   cur <= S_WB_ALU;
                S_MEM_ADDR: cur <= (opcode == OP_STORE) ? S_MEM_WR : S_MEM_RD;
                S_MEM_RD:   if (mem.mem_ready) cur <= S_WB_MEM;
                S_MEM_WR:   if (mem.mem_ready) cur <= S_FETCH;
                S_WB_ALU:   cur <= S_FETCH;
                S_WB_MEM:   cur <= S_FETCH;
                S_BRANCH:   cur <= S_FETCH;
                S_TRAP:     cur <= S_TRAP;
                default:    cur <= S_TRAP;
            endcase
        end
    end

    // Outputs are gated by reset so an abandoned access drops in the reset cycle itself.
    always_comb begin
        req        = 1'b0;
        we         = 1'b0;
        asel       = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        pc_src     = 1'b0;
        reg_write  = 1'b0;
        result_src = 1'b0;
        alu_src_b  = 1'b0;
        alu_op     = ALU_ADD;
        trap       = 1'b0;
        state      = 4'd0;
        if (!reset) begin
            state = cur;
            case (cur)
                S_FETCH: begin
                    req      = 1'b1;
                    ir_write = mem.mem_ready;
                    pc_write = mem.mem_ready;
                end
                S_EXEC_R: begin
                    alu_op = exec_op;
                end
                S_EXEC_I: begin
                    alu_op    = exec_op;
                    alu_src_b = 1'b1;
                end
                S_MEM_ADDR: begin
                    alu_op    = ALU_ADD;
                    alu_src_b = 1'b1;
                end
                S_MEM_RD: begin
                    req  = 1'b1;
                    asel = 1'b1;
                end
                S_MEM_WR: begin
                    req  = 1'b1;
                    we   = 1'b1;
                    asel = 1'b1;
                end
                S_WB_ALU: begin
                    reg_write = rd_nonzero;
                end
                S_WB_MEM: begin
                    reg_write  = rd_nonzero;
                    result_src = 1'b1;
                end
                S_BRANCH: begin
                    alu_op   = ALU_SUB;
                    pc_write = alu_zero;
                    pc_src   = 1'b1;
                end
                S_TRAP: begin
                    trap = 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign mem.mem_req  = req;
    assign mem.mem_we   = we;
    assign mem.addr_sel = asel;

`ifdef MULTICYCLE_CONTROL_PERF_EN
    logic [31:0] cycle_q;
    logic [31:0] instret_q;
    logic        retire;

    assign retire = (cur == S_WB_ALU) || (cur == S_WB_MEM) || (cur == S_BRANCH) ||
                    (cur == S_MEM_WR && mem.mem_ready);

    always_ff @(posedge clk) begin
        if (reset) begin
            cycle_q   <= '0;
            instret_q <= '0;
        end else begin
            if (cur != S_TRAP)
                cycle_q <= cycle_q + 32'd1;
            if (retire)
                instret_q <= instret_q + 32'd1;
        end
    end

    assign cycle_count   = reset ? '0 : cycle_q;
    assign instret_count = reset ? '0 : instret_q;
`else
    assign cycle_count   = '0;
    assign instret_count = '0;
`endif

endmodule

// File: doc/multicycle_control.md
# multicycle_control

Multi-cycle sequencer for the RV32I datapath (pc, register_file, alu, sign_extend, shared instruction/data memory port). Drives the per-state control strobes so one instruction completes over 3–5 cycles, handshaking with a variable-latency memory. Sits beside the datapath inside cpu and replaces the free-running pc_plus_4 update.

## Interface
- No parameters.
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- instr  in  32  current instruction register contents (valid from DECODE onward)
- alu_zero  in  1  ALU result == 0
- mem_ready  in  1  memory completes the pending access this cycle
- mem_req  out  1  memory access request
- mem_we  out  1  1 = write, 0 = read
- addr_sel  out  1  memory address: 0 = PC, 1 = ALU result register
- ir_write  out  1  load instr register from memory read data
- pc_write  out  1  load PC
- pc_src  out  1  0 = PC+4, 1 = branch target
- reg_write  out  1  register_file write_enable
- result_src  out  1  write-back data: 0 = ALU, 1 = memory
- alu_src_b  out  1  0 = rs2 data, 1 = sign-extended immediate
- alu_op  out  3  ADD=0 SUB=1 AND=2 OR=3 XOR=4 SLL=5 SRL=6 SLT=7
- trap  out  1  sticky illegal-instruction flag
- state  out  4  current state encoding
- cycle_count  out  32  see Configuration
- instret_count  out  32  see Configuration

## Operation
- States: FETCH=0, DECODE=1, EXEC_R=2, EXEC_I=3, MEM_ADDR=4, MEM_RD=5, MEM_WR=6, WB_ALU=7, WB_MEM=8, BRANCH=9, TRAP=10.
- Moore outputs decoded from state, except ir_write/pc_write in FETCH and pc_write in BRANCH (qualified by mem_ready/alu_zero). Unlisted outputs are 0.
- FETCH: mem_req=1, addr_sel=0. On mem_ready: ir_write=1, pc_write=1, pc_src=0 → DECODE; else stay.
- DECODE (instr[6:0]): 0110011 → EXEC_R; 0010011 → EXEC_I; 0000011 with funct3=010 → MEM_ADDR; 0100011 with funct3=010 → MEM_ADDR; 1100011 with funct3=000 → BRANCH; anything else → TRAP.
- alu_op decode (EXEC_R/EXEC_I), funct3: 000 ADD (SUB if R-type and funct7=0100000); 001 SLL; 010 SLT; 100 XOR; 101 SRL; 110 OR; 111 AND. funct3=011, funct7=0100000 with 101, or any other nonzero funct7 in R-type → TRAP (detected in DECODE).
- EXEC_R: alu_src_b=0 → WB_ALU. EXEC_I: alu_src_b=1 → WB_ALU.
- WB_ALU: reg_write=1 (0 if instr[11:7]=0), result_src=0 → FETCH.
- MEM_ADDR: alu_op=ADD, alu_src_b=1 → MEM_RD (load) or MEM_WR (store).
- MEM_RD: mem_req=1, addr_sel=1; on mem_ready → WB_MEM.
- MEM_WR: mem_req=1, mem_we=1, addr_sel=1; on mem_ready → FETCH.
- WB_MEM: reg_write=1 (0 if rd=0), result_src=1 → FETCH.
- BRANCH: alu_op=SUB, alu_src_b=0; pc_write=alu_zero, pc_src=1 → FETCH.
- TRAP: trap=1, all strobes 0, remains until reset.

## Timing
- reset asserted: next state FETCH, trap=0, counters 0; all outputs 0 during the reset cycle; first mem_req in the cycle after reset deasserts.
- Memory handshake: mem_req held high and address/mem_we stable until a cycle with mem_ready=1; mem_ready while mem_req=0 ignored; zero-wait (mem_ready in first request cycle) allowed.
- Cycles per instruction with zero-wait memory: BEQ 3, R/I-ALU 4, SW 4, LW 5; each wait cycle adds 1.
- Reset mid-instruction: abandon access (mem_req drops with the reset cycle), no register or PC write.

## Configuration
- MULTICYCLE_CONTROL_PERF_EN defined: cycle_count +1 every cycle out of reset and not in TRAP; instret_count +1 on leaving WB_ALU, WB_MEM, BRANCH, or MEM_WR with mem_ready; both wrap 0xFFFFFFFF → 0.
- Undefined: counters not built, cycle_count and instret_count tied to 0.

## Test plan
- Reset then instr=0x005303b3 (add x7,x6,x5), mem_ready always 1 → states 0,1,2,7,0; alu_op=0, reg_write=1 in WB_ALU; instret_count=1 after 4 cycles.
- instr=0x40530333 (sub x6,x6,x5) → alu_op=1 in EXEC_R; instr=0x00000033 (add x0) → reg_write=0 in WB_ALU.
- lw x1,4(x2) (0x00412083), mem_ready low 3 cycles in MEM_RD → mem_req=1, addr_sel=1 held 4 cycles, then WB_MEM with result_src=1; 8 cycles total.
- beq (0x00208463) with alu_zero=1 → pc_write=1, pc_src=1 in BRANCH; with alu_zero=0 → pc_write=0; both return to FETCH after 3 cycles.
- instr=0xFFFFFFFF → TRAP, trap=1, mem_req=0 for 20 cycles; reset → FETCH, trap=0.
- Reset asserted in MEM_WR with mem_ready=0 → all outputs 0 that cycle, state=FETCH next, no mem_we pulse completes.
